// File: rtl/int_to_float.sv
// int_to_float: pipelined two's-complement integer to float converter.
//
// Each cycle accepts one sample qualified by in_valid. The result comes out
// four cycles later: a sample taken at edge N shows on out/out_valid after
// edge N+4.
//
// Register stages:
//   s1 : sign and magnitude of the input
//   s2 : leading-zero count and zero flag
//   s3 : normalised fraction (mantissa + guard) and biased exponent
//   s4 : rounded mantissa and exponent
//   out: packed float, with zero / infinity / underflow handling
//
// EXPONENT_BIAS_OFFSET is added to the standard bias. This lets the block
// scale fixed-point inputs by a power of two at no extra cost.
//
// Optional build macro INT_TO_FLOAT_ROUND_EN:
//   defined   - round to nearest, ties away from zero, on the guard bit only
//   undefined - truncate toward zero; no carry path
module int_to_float #(
    parameter int MANTISSA_SIZE        = 23,
    parameter int EXPONENT_SIZE        = 8,
    parameter int INT_SIZE             = 32,
    parameter int EXPONENT_BIAS_OFFSET = 0,
    localparam int FLOAT_SIZE          = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [INT_SIZE-1:0]   in,
    output logic                  out_valid,
    output logic [FLOAT_SIZE-1:0] out
);

    localparam int LZW = $clog2(INT_SIZE) + 1;
    localparam int EW  = EXPONENT_SIZE + 2;
    localparam int FW  = MANTISSA_SIZE + 1;
    // exponent for lzc = 0, already biased; lzc is subtracted in stage 3
    localparam int EXP_BASE = INT_SIZE - 1 + (2 ** (EXPONENT_SIZE - 1)) - 1
                              + EXPONENT_BIAS_OFFSET;
    localparam logic [EW-1:0] EXP_MAX = EW'((2 ** EXPONENT_SIZE) - 1);

    // stage 1 signals
    logic                sign_in;
    logic [INT_SIZE-1:0] mag_in;
    logic                v_s1;
    logic                sign_s1;
    logic [INT_SIZE-1:0] mag_s1;

    // stage 2 signals
    logic [LZW-1:0]      lzc_s1;
    logic                v_s2;
    logic                sign_s2;
    logic                zero_s2;
    logic [INT_SIZE-1:0] mag_s2;
    logic [LZW-1:0]      lzc_s2;

    // stage 3 signals
    logic [INT_SIZE-1:0] norm_full;
    logic [FW-1:0]       frac_n;
    logic [EW-1:0]       exp_n;
    logic                v_s3;
    logic                sign_s3;
    logic                zero_s3;
    logic [FW-1:0]       frac_s3;
    logic [EW-1:0]       exp_s3;

    // stage 4 signals
    logic [MANTISSA_SIZE-1:0] mant_rnd;
    logic [EW-1:0]            exp_rnd;
    logic                     v_s4;
    logic                     sign_s4;
    logic                     zero_s4;
    logic [MANTISSA_SIZE-1:0] mant_s4;
    logic [EW-1:0]            exp_s4;

    // output packing
    logic [FLOAT_SIZE-1:0] pack;

    // The shift result keeps its hidden bit and low bits only for slicing.
    // The guard bit is unused when rounding is compiled out.
    logic unused_bits;
    assign unused_bits = ^{norm_full, frac_s3};

    // Unpack. The most negative input wraps to 2^(INT_SIZE-1), which is the
    // correct unsigned magnitude.
    assign sign_in = in[INT_SIZE-1];
    assign mag_in  = sign_in ? (~in + INT_SIZE'(1)) : in;

    // Stage 1 register: sign/magnitude
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_s1    <= 1'b0;
            sign_s1 <= 1'b0;
            mag_s1  <= '0;
        end else begin
            v_s1    <= in_valid;
            sign_s1 <= sign_in;
            mag_s1  <= mag_in;
        end
    end

    // Leading-zero count. The highest set bit wins; a zero magnitude gives
    // INT_SIZE.
    always_comb begin
        lzc_s1 = LZW'(INT_SIZE);
        for (int i = 0; i < INT_SIZE; i++) begin
            if (mag_s1[i]) lzc_s1 = LZW'(INT_SIZE - 1 - i);
        end
    end

    // Stage 2 register: count and zero flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_s2    <= 1'b0;
            sign_s2 <= 1'b0;
            zero_s2 <= 1'b0;
            mag_s2  <= '0;
            lzc_s2  <= '0;
        end else begin
            v_s2    <= v_s1;
            sign_s2 <= sign_s1;
            zero_s2 <= (mag_s1 == '0);
            mag_s2  <= mag_s1;
            lzc_s2  <= lzc_s1;
        end
    end

    // Normalise so the leading one sits at bit INT_SIZE-1. Keep only the
    // mantissa bits and the guard bit below them.
    always_comb begin
        norm_full = mag_s2 << lzc_s2;
        frac_n    = norm_full[INT_SIZE-2 -: FW];
        exp_n     = EW'(EXP_BASE - int'(lzc_s2));
    end

    // Stage 3 register: fraction and biased exponent
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_s3    <= 1'b0;
            sign_s3 <= 1'b0;
            zero_s3 <= 1'b0;
            frac_s3 <= '0;
            exp_s3  <= '0;
        end else begin
            v_s3    <= v_s2;
            sign_s3 <= sign_s2;
            zero_s3 <= zero_s2;
            frac_s3 <= frac_n;
            exp_s3  <= exp_n;
        end
    end

`ifdef INT_TO_FLOAT_ROUND_EN
    logic [FW-1:0] mant_sum;

    // Round on the guard bit, ties away from zero. On carry-out the mantissa
    // wraps to zero and the exponent steps up.
    always_comb begin
        mant_sum = {1'b0, frac_s3[FW-1:1]} + FW'(frac_s3[0]);
        mant_rnd = mant_sum[MANTISSA_SIZE-1:0];
        exp_rnd  = exp_s3 + EW'(mant_sum[MANTISSA_SIZE]);
    end
`else
    // Truncate toward zero: drop the guard bit
    always_comb begin
        mant_rnd = frac_s3[FW-1:1];
        exp_rnd  = exp_s3;
    end
`endif

    // Stage 4 register: rounded mantissa/exponent
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_s4    <= 1'b0;
            sign_s4 <= 1'b0;
            zero_s4 <= 1'b0;
            mant_s4 <= '0;
            exp_s4  <= '0;
        end else begin
            v_s4    <= v_s3;
            sign_s4 <= sign_s3;
            zero_s4 <= zero_s3;
            mant_s4 <= mant_rnd;
            exp_s4  <= exp_rnd;
        end
    end

    // Pack the result. A zero input gives +0. A non-positive exponent flushes
    // to a signed zero (there are no denormals). An exponent that reaches
    // all-ones saturates to a signed infinity.
    always_comb begin
        pack = '0;
        if (zero_s4) begin
            pack = '0;
        end else if (exp_s4[EW-1] || (exp_s4 == '0)) begin
            pack = {sign_s4, {(EXPONENT_SIZE + MANTISSA_SIZE){1'b0}}};
        end else if (exp_s4 >= EXP_MAX) begin
            pack = {sign_s4, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
        end else begin
            pack = {sign_s4, exp_s4[EXPONENT_SIZE-1:0], mant_s4};
        end
    end

    // Output register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= v_s4;
            out       <= pack;
        end
    end

endmodule
